ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single RAM port between NREQ requesters (icache fill, dcache fill/writeback, per core), in front of memory_control.
//  Round-robin grant, held for a BURST_LEN-word block transfer; words complete on ram_state==ACCESS.
//  Drives the per-requester wait/load signals; a granted requester sees a plain RAM port.
// PARAMETERS
//  NREQ       2   number of requesters (>=2)
//  AW        32   address width
//  DW        32   data width
//  BURST_LEN  2   words per grant (block size); 1 = single-word grants
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        asynchronous, active-high reset
//  req_ren    in   NREQ     read request, one bit per requester
//  req_wen    in   NREQ     write request, one bit per requester
//  req_addr   in   NREQ*AW  word address, requester i at [i*AW +: AW]
//  req_store  in   NREQ*DW  write data, requester i at [i*DW +: DW]
//  req_wait   out  NREQ     1 = requester must hold; 0 = current word done this cycle
//  req_load   out  DW       read data (ram_load passthrough, valid for owner when its wait=0)
//  ram_ren    out  1        RAM read enable
//  ram_wen    out  1        RAM write enable
//  ram_addr   out  AW       RAM address
//  ram_store  out  DW       RAM write data
//  ram_load   in   DW       RAM read data
//  ram_state  in   2        FREE=0 BUSY=1 ACCESS=2 ERROR=3 (cpu_types_pkg ramstate_t)
//  grant_vld  out  1        a requester owns the port (state XFER)
//  grant_id   out  $clog2(NREQ)  current owner (last owner when idle)
//  ram_err    out  1        sticky: ram_state==ERROR seen while granted; cleared by reset only
// BEHAVIOUR
//  Reset (async, RST=1): state IDLE, owner=NREQ-1 (requester 0 wins first), count=0, ram_err=0;
//   outputs: req_wait all 1, ram_ren=ram_wen=0, ram_addr=ram_store=0, grant_vld=0, grant_id=NREQ-1.
//  Reset mid-burst aborts immediately; RAM enables drop in the same cycle; no partial-word bookkeeping.
//  States: IDLE, XFER.
//  IDLE: all RAM outputs 0, req_wait all 1. active_i = req_ren[i]|req_wen[i].
//   If any active: new owner = first active index scanning owner+1, owner+2, ... (mod NREQ); count<=0; ->XFER.
//   Grant latency: request seen at edge t -> ram_ren/ram_wen asserted in cycle t+1 (one arbitration cycle).
//  XFER: ram_addr/ram_store = owner's req_addr/req_store (combinational, follows per-word address changes).
//   ram_wen = req_wen[owner]; ram_ren = req_ren[owner] & ~req_wen[owner] (write wins if both set).
//   req_wait[owner] = ~(ram_state==ACCESS); all non-owners req_wait=1. req_load=ram_load always.
//   Word done = (ram_state==ACCESS) & active_owner. On word done: count<=count+1;
//    if count==BURST_LEN-1 -> IDLE, count<=0 (owner kept as round-robin pointer).
//   Owner drops both ren and wen before burst ends -> IDLE next edge, RAM enables low that cycle (abort).
//   ram_state FREE/BUSY: hold, wait stays 1. ERROR: hold, wait 1, ram_err<=1; grant not released
//    (requester must drop request to recover).
//  Direction may change between words of one burst (writeback then fill), still counted in the same burst.
//  Count width $clog2(BURST_LEN)+1; never exceeds BURST_LEN-1; wraps to 0 only via IDLE.
//  Fairness: after a completed or aborted grant to i, every other continuously-active requester
//   is served before i again; worst-case wait = (NREQ-1) bursts + NREQ arbitration cycles.
//  Requests from non-owners during XFER are only sampled at the next IDLE; no pre-emption.
//  grant_vld = (state==XFER); grant_id = owner.
// TESTING
//  1 Reset: RST=1 mid-XFER with req_ren[1]=1 -> same cycle ram_ren=0, req_wait=2'b11, grant_vld=0; after release req 0 first.
//  2 Single read burst: req_ren[0]=1 addr 0x100/0x104, ram_state ACCESS every cycle -> ram_ren in cycles 1-2, req_wait[0]=0 in
//    cycles 1-2, req_load=ram_load, IDLE in cycle 3.
//  3 Contention: req_ren=2'b11 held continuously -> grants alternate 0,1,0,1; each grant exactly 2 ACCESS words; non-owner wait=1 throughout.
//  4 Latency: ram_state BUSY 3 cycles then ACCESS per word -> owner wait=1 while BUSY, word count advances only on ACCESS; burst takes 8 cycles.
//  5 Mixed/abort: owner 1 sets ren&wen -> ram_wen=1, ram_ren=0; owner drops both after word 1 -> IDLE next edge, requester 0 granted next.
//  6 Error: ram_state=ERROR during XFER -> ram_err=1 sticky, wait held 1; owner drops request -> IDLE; ram_err stays 1 until RST.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the shared RAM port arbiter.
// The arbiter uses the slave view; requesters plus memory_control together form the master view.
interface ram_port_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_ren;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_store;
    logic [NREQ-1:0]    req_wait;
    logic [DW-1:0]      req_load;
    logic               ram_ren;
    logic               ram_wen;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_store;
    logic [DW-1:0]      ram_load;
    logic [1:0]         ram_state;
    logic               grant_vld;
    logic [IW-1:0]      grant_id;
    logic               ram_err;

    modport slave (
        input  req_ren, req_wen, req_addr, req_store, ram_load, ram_state,
        output req_wait, req_load, ram_ren, ram_wen, ram_addr, ram_store,
               grant_vld, grant_id, ram_err
    );

    modport master (
        output req_ren, req_wen, req_addr, req_store, ram_load, ram_state,
        input  req_wait, req_load, ram_ren, ram_wen, ram_addr, ram_store,
               grant_vld, grant_id, ram_err
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters; each grant is held
// for a BURST_LEN-word block, with words completing when memory reports ACCESS.
module ram_port_arbiter #(
    parameter int NREQ      = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_LEN = 2
) (
    input  logic              CLK,
    input  logic              RST,
    ram_port_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [1:0]    RS_ACCESS = 2'd2;
    localparam logic [1:0]    RS_ERROR  = 2'd3;
    localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LEN - 1);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next, rr_pick, rr_idx;
    logic [CW-1:0]   count_reg, count_next;
    logic            ram_err_reg, ram_err_next;
    logic [NREQ-1:0] active;
    logic            xfer, access, active_owner;

    assign active       = bus.req_ren | bus.req_wen;
    assign xfer         = (state_reg == XFER);
    assign access       = (bus.ram_state == RS_ACCESS);
    assign active_owner = active[owner_reg];

    // Scan from farthest to nearest so the requester just after the owner wins;
    // the owner itself (k == NREQ) has the lowest priority.
    always_comb begin
        rr_pick = owner_reg;
        rr_idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            rr_idx = IW'((int'(owner_reg) + k) % NREQ);
            if (active[rr_idx]) rr_pick = rr_idx;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        count_next   = count_reg;
        ram_err_next = ram_err_reg;
        case (state_reg)
            IDLE: begin
                if (|active) begin
                    state_next = XFER;
                    owner_next = rr_pick;
                    count_next = '0;
                end
            end
            XFER: begin
                if (bus.ram_state == RS_ERROR) ram_err_next = 1'b1;
                // Owner withdrawing its request is the only way out of a stuck or errored burst.
                if (!active_owner) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (access) begin
                    if (count_reg == LAST_WORD) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            owner_reg   <= IW'(NREQ - 1);
            count_reg   <= '0;
            ram_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            count_reg   <= count_next;
            ram_err_reg <= ram_err_next;
        end
    end

    // Write wins when the owner raises both enables.
    always_comb begin
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
        if (xfer) begin
            bus.ram_wen   = bus.req_wen[owner_reg];
            bus.ram_ren   = bus.req_ren[owner_reg] & ~bus.req_wen[owner_reg];
            bus.ram_addr  = bus.req_addr[owner_reg*AW +: AW];
            bus.ram_store = bus.req_store[owner_reg*DW +: DW];
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_wait
            assign bus.req_wait[gi] = ~(xfer && (owner_reg == IW'(gi)) && access);
        end
    endgenerate

    assign bus.req_load  = bus.ram_load;
    assign bus.grant_vld = xfer;
    assign bus.grant_id  = owner_reg;
    assign bus.ram_err   = ram_err_reg;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: scenario tasks drive requesters and RAM state, expected
// word completions are queued up front and popped as the arbiter finishes each word.
module tb_ram_port_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BL   = 2;
    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    ram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .BURST_LEN(BL)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_ren   = '0;
        bus.req_wen   = '0;
        bus.req_addr  = '0;
        bus.req_store = '0;
        bus.ram_load  = '0;
        bus.ram_state = S_FREE;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_inputs();
        step();
        RST = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        step();
        tests++;
        if (bus.req_wait !== 2'b11 || bus.ram_ren !== 1'b0 || bus.ram_wen !== 1'b0 ||
            bus.ram_addr !== 32'h0 || bus.ram_store !== 32'h0) begin
            fails++;
            $display("FAIL reset_port: wait=%b ren=%b wen=%b addr=%h store=%h required wait=11 ren=0 wen=0 addr=0 store=0",
                     bus.req_wait, bus.ram_ren, bus.ram_wen, bus.ram_addr, bus.ram_store);
        end
        tests++;
        if (bus.grant_vld !== 1'b0 || bus.grant_id !== 1'b1 || bus.ram_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_grant: vld=%b id=%0d err=%b required vld=0 id=1 err=0",
                     bus.grant_vld, bus.grant_id, bus.ram_err);
        end
        RST = 1'b0;
        bus.ram_state = S_BUSY;
        bus.req_ren   = 2'b10;
        step();
        tests++;
        if (bus.grant_vld !== 1'b1 || bus.grant_id !== 1'b1 || bus.ram_ren !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_grant: vld=%b id=%0d ren=%b required vld=1 id=1 ren=1",
                     bus.grant_vld, bus.grant_id, bus.ram_ren);
        end
        #1;
        RST = 1'b1;
        #1;
        tests++;
        if (bus.ram_ren !== 1'b0 || bus.req_wait !== 2'b11 || bus.grant_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_async_abort: ren=%b wait=%b vld=%b required ren=0 wait=11 vld=0",
                     bus.ram_ren, bus.req_wait, bus.grant_vld);
        end
        step();
        RST = 1'b0;
        bus.req_ren = 2'b11;
        step();
        tests++;
        if (bus.grant_vld !== 1'b1 || bus.grant_id !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_winner: vld=%b id=%0d required vld=1 id=0", bus.grant_vld, bus.grant_id);
        end
        clear_inputs();
    endtask

    task automatic test_single_read();
        exp_t e;
        int   w = 0;
        do_reset();
        bus.ram_state = S_ACCESS;
        bus.req_ren   = 2'b01;
        exp_q.push_back('{0, 32'h100, 1'b0, 32'h0, 1});
        exp_q.push_back('{0, 32'h104, 1'b0, 32'h0, 2});
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (w < 2) bus.req_addr[0 +: AW] = 32'h100 + 32'(4 * w);
            else bus.req_ren = 2'b00;
            bus.ram_load = $urandom;
            #1;
            if (cyc == 0) begin
                tests++;
                if (bus.ram_ren !== 1'b0 || bus.req_wait !== 2'b11) begin
                    fails++;
                    $display("FAIL single_arb_cycle: ren=%b wait=%b required ren=0 wait=11", bus.ram_ren, bus.req_wait);
                end
            end
            if (bus.req_wait[0] === 1'b0 && bus.req_ren[0]) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL single_word: unexpected completion in cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.ram_addr !== e.addr || cyc != e.cyc || bus.ram_ren !== 1'b1 ||
                        bus.req_load !== bus.ram_load) begin
                        fails++;
                        $display("FAIL single_word: addr=%h cyc=%0d ren=%b load=%h required addr=%h cyc=%0d ren=1 load=%h",
                                 bus.ram_addr, cyc, bus.ram_ren, bus.req_load, e.addr, e.cyc, bus.ram_load);
                    end
                end
                w++;
            end
            if (cyc == 3) begin
                tests++;
                if (bus.grant_vld !== 1'b0 || bus.ram_ren !== 1'b0) begin
                    fails++;
                    $display("FAIL single_idle_after: vld=%b ren=%b required vld=0 ren=0", bus.grant_vld, bus.ram_ren);
                end
            end
            step();
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL single_leftover: %0d words outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_contention();
        exp_t e;
        int   w[2] = '{0, 0};
        int   seq_id[8]  = '{0, 0, 1, 1, 0, 0, 1, 1};
        int   seq_cyc[8] = '{1, 2, 4, 5, 7, 8, 10, 11};
        int   seq_w[8]   = '{0, 1, 0, 1, 2, 3, 2, 3};
        do_reset();
        bus.ram_state = S_ACCESS;
        bus.req_ren   = 2'b11;
        for (int n = 0; n < 8; n++)
            exp_q.push_back('{seq_id[n], 32'h1000 * (seq_id[n] + 1) + 32'(4 * seq_w[n]), 1'b0, 32'h0, seq_cyc[n]});
        for (int cyc = 0; cyc < 13; cyc++) begin
            for (int i = 0; i < NREQ; i++) bus.req_addr[i*AW +: AW] = 32'h1000 * (i + 1) + 32'(4 * w[i]);
            #1;
            if (bus.grant_vld === 1'b1) begin
                tests++;
                if (bus.req_wait[~bus.grant_id] !== 1'b1) begin
                    fails++;
                    $display("FAIL contention_nonowner_wait: cyc=%0d wait=%b owner=%0d required nonowner wait=1",
                             cyc, bus.req_wait, bus.grant_id);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_wait[i] === 1'b0 && bus.req_ren[i]) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL contention_word: unexpected completion by %0d in cycle %0d", i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (i != e.id || bus.grant_id !== 1'(e.id) || bus.ram_addr !== e.addr || cyc != e.cyc) begin
                            fails++;
                            $display("FAIL contention_word: id=%0d grant=%0d addr=%h cyc=%0d required id=%0d addr=%h cyc=%0d",
                                     i, bus.grant_id, bus.ram_addr, cyc, e.id, e.addr, e.cyc);
                        end
                    end
                    w[i]++;
                end
            end
            step();
        end
        clear_inputs();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL contention_leftover: %0d words outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_latency();
        exp_t e;
        int   w = 0;
        do_reset();
        bus.req_ren = 2'b01;
        exp_q.push_back('{0, 32'h400, 1'b0, 32'h0, 4});
        exp_q.push_back('{0, 32'h404, 1'b0, 32'h0, 8});
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.ram_state = (cyc >= 1 && cyc % 4 == 0) ? S_ACCESS : S_BUSY;
            if (w < 2) bus.req_addr[0 +: AW] = 32'h400 + 32'(4 * w);
            else bus.req_ren = 2'b00;
            #1;
            if (cyc >= 1 && cyc <= 8 && bus.ram_state == S_BUSY) begin
                tests++;
                if (bus.req_wait[0] !== 1'b1 || bus.ram_ren !== 1'b1 || bus.grant_vld !== 1'b1) begin
                    fails++;
                    $display("FAIL latency_busy_hold: cyc=%0d wait0=%b ren=%b vld=%b required wait0=1 ren=1 vld=1",
                             cyc, bus.req_wait[0], bus.ram_ren, bus.grant_vld);
                end
            end
            if (bus.req_wait[0] === 1'b0 && bus.req_ren[0]) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL latency_word: unexpected completion in cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.ram_addr !== e.addr || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL latency_word: addr=%h cyc=%0d required addr=%h cyc=%0d",
                                 bus.ram_addr, cyc, e.addr, e.cyc);
                    end
                end
                w++;
            end
            if (cyc == 9) begin
                tests++;
                if (bus.grant_vld !== 1'b0) begin
                    fails++;
                    $display("FAIL latency_burst_end: vld=%b required 0 after 8 cycles", bus.grant_vld);
                end
            end
            step();
        end
        clear_inputs();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL latency_leftover: %0d words outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_mixed_abort();
        exp_t e;
        do_reset();
        bus.ram_state = S_ACCESS;
        bus.req_ren   = 2'b10;
        bus.req_wen   = 2'b10;
        bus.req_addr[AW +: AW]  = 32'h200;
        bus.req_store[DW +: DW] = 32'hDEAD0001;
        exp_q.push_back('{1, 32'h200, 1'b1, 32'hDEAD0001, 1});
        exp_q.push_back('{0, 32'h300, 1'b0, 32'h0, 4});
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 1) begin
                bus.req_ren[0]         = 1'b1;
                bus.req_addr[0 +: AW]  = 32'h300;
                bus.req_store[0 +: DW] = 32'h0;
            end
            if (cyc == 2) begin
                bus.req_ren[1] = 1'b0;
                bus.req_wen[1] = 1'b0;
            end
            if (cyc == 5) bus.req_ren[0] = 1'b0;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_wait[i] === 1'b0 && (bus.req_ren[i] | bus.req_wen[i])) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL mixed_word: unexpected completion by %0d in cycle %0d", i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (i != e.id || bus.ram_addr !== e.addr || bus.ram_wen !== e.wen ||
                            bus.ram_ren !== ~e.wen || bus.ram_store !== e.data || cyc != e.cyc) begin
                            fails++;
                            $display("FAIL mixed_word: id=%0d addr=%h wen=%b ren=%b store=%h cyc=%0d required id=%0d addr=%h wen=%b ren=%b store=%h cyc=%0d",
                                     i, bus.ram_addr, bus.ram_wen, bus.ram_ren, bus.ram_store, cyc,
                                     e.id, e.addr, e.wen, ~e.wen, e.data, e.cyc);
                        end
                    end
                end
            end
            if (cyc == 1) begin
                tests++;
                if (bus.req_wait[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL mixed_no_preempt: wait0=%b required 1", bus.req_wait[0]);
                end
            end
            if (cyc == 2) begin
                tests++;
                if (bus.ram_ren !== 1'b0 || bus.ram_wen !== 1'b0 || bus.grant_vld !== 1'b1) begin
                    fails++;
                    $display("FAIL mixed_abort_cycle: ren=%b wen=%b vld=%b required ren=0 wen=0 vld=1",
                             bus.ram_ren, bus.ram_wen, bus.grant_vld);
                end
            end
            if (cyc == 3) begin
                tests++;
                if (bus.grant_vld !== 1'b0) begin
                    fails++;
                    $display("FAIL mixed_abort_idle: vld=%b required 0", bus.grant_vld);
                end
            end
            if (cyc == 4) begin
                tests++;
                if (bus.grant_vld !== 1'b1 || bus.grant_id !== 1'b0) begin
                    fails++;
                    $display("FAIL mixed_next_owner: vld=%b id=%0d required vld=1 id=0", bus.grant_vld, bus.grant_id);
                end
            end
            step();
        end
        clear_inputs();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL mixed_leftover: %0d words outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_error();
        do_reset();
        bus.ram_state = S_ERROR;
        bus.req_ren   = 2'b01;
        bus.req_addr[0 +: AW] = 32'h500;
        step();
        tests++;
        if (bus.ram_err !== 1'b0 || bus.req_wait[0] !== 1'b1 || bus.grant_vld !== 1'b1) begin
            fails++;
            $display("FAIL error_idle_ignored: err=%b wait0=%b vld=%b required err=0 wait0=1 vld=1",
                     bus.ram_err, bus.req_wait[0], bus.grant_vld);
        end
        step();
        bus.req_ren   = 2'b00;
        bus.ram_state = S_FREE;
        #1;
        tests++;
        if (bus.ram_err !== 1'b1 || bus.grant_vld !== 1'b1 || bus.req_wait[0] !== 1'b1) begin
            fails++;
            $display("FAIL error_flag_hold: err=%b vld=%b wait0=%b required err=1 vld=1 wait0=1",
                     bus.ram_err, bus.grant_vld, bus.req_wait[0]);
        end
        step();
        tests++;
        if (bus.grant_vld !== 1'b0 || bus.ram_err !== 1'b1) begin
            fails++;
            $display("FAIL error_release: vld=%b err=%b required vld=0 err=1", bus.grant_vld, bus.ram_err);
        end
        for (int n = 0; n < 3; n++) step();
        tests++;
        if (bus.ram_err !== 1'b1) begin
            fails++;
            $display("FAIL error_sticky: err=%b required 1", bus.ram_err);
        end
        RST = 1'b1;
        #1;
        tests++;
        if (bus.ram_err !== 1'b0) begin
            fails++;
            $display("FAIL error_reset_clear: err=%b required 0", bus.ram_err);
        end
        step();
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_latency();
        test_mixed_abort();
        test_error();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
